bw_memreq_arb: RTL and testbench

BW_MEMREQ_ARB -- requirements
Module: bw_memreq_arb

---
 rtl/bw_memreq_arb_pkg.sv | 26 ++
 rtl/bw_rr_arb2.sv | 29 ++
 rtl/bw_memreq_arb.sv | 117 +++++++++++
 tb/tb_bw_memreq_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_memreq_arb_pkg.sv
// Shared memory-request/response types for the BlackWidow memory arbiter slice.
package rfBlackWidowPkg;

    localparam int ARB_PORTS = 2;

    typedef logic [31:0] Address;

    // 315 bits; tid[7] carries the originating arbiter port.
    typedef struct packed {
        logic [7:0]   tid;
        Address       addr;
        logic [2:0]   cmd;
        logic [15:0]  be;
        logic [255:0] data;
    } MemoryRequest;

    // 619 bits; tid echoes the request tid.
    typedef struct packed {
        logic [7:0]   tid;
        Address       addr;
        logic [2:0]   status;
        logic [63:0]  ecc;
        logic [511:0] data;
    } MemoryResponse;

endpackage

// File: rtl/bw_rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer.
// Latency: grant is combinational from eligible; pointer updates on the grant edge.
// Backpressure: none here; callers fold downstream readiness into eligible.
module bw_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] eligible,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last
);

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 lets port 0 win the first conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/bw_memreq_arb.sv
// Arbitrates I-cache and LSU memory requests onto one channel and routes responses back by tid.
// Latency: 1 cycle grant to mreq_v_o, 1 cycle mresp_v_i to resp_v_o.
// Backpressure: a stalled output register or a port at MAX_OUT outstanding withholds req_rdy_o.
module bw_memreq_arb
    import rfBlackWidowPkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  MemoryRequest  req0_i,
    input  MemoryRequest  req1_i,
    input  logic [1:0]    req_v_i,
    output logic [1:0]    req_rdy_o,
    output MemoryRequest  mreq_o,
    output logic          mreq_v_o,
    input  logic          mreq_rdy_i,
    input  MemoryResponse mresp_i,
    input  logic          mresp_v_i,
    output MemoryResponse resp0_o,
    output MemoryResponse resp1_o,
    output logic [1:0]    resp_v_o,
    output logic [3:0]    outst0_o,
    output logic [3:0]    outst1_o,
    output logic          err_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic [ARB_PORTS-1:0][3:0] outst;
    logic [ARB_PORTS-1:0][6:0] seq;
    logic [ARB_PORTS-1:0]      eligible;
    logic [ARB_PORTS-1:0]      grant;
    logic [ARB_PORTS-1:0]      dec;
    logic                      reg_free;
    logic                      orphan;
    logic                      gnt_port;
    logic                      last_gnt;
    MemoryRequest              sel_req;

    assign reg_free = !mreq_v_o || mreq_rdy_i;

    always_comb begin
        eligible = '0;
        dec      = '0;
        for (int p = 0; p < ARB_PORTS; p++) begin
            eligible[p] = !rst_i && req_v_i[p] && (outst[p] < MAX_CNT) && reg_free;
            dec[p]      = mresp_v_i && (mresp_i.tid[7] == 1'(p)) && (outst[p] != 4'd0);
        end
    end

    // A response that cannot retire any outstanding entry is an orphan.
    assign orphan = mresp_v_i && (dec == '0);

    bw_rr_arb2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .eligible (eligible),
        .advance  (|eligible),
        .grant    (grant),
        .last     (last_gnt)
    );

    assign req_rdy_o = grant;
    assign gnt_port  = grant[1];
    assign sel_req   = gnt_port ? req1_i : req0_i;
    assign outst0_o  = outst[0];
    assign outst1_o  = outst[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mreq_v_o <= 1'b0;
            resp_v_o <= '0;
            err_o    <= 1'b0;
            outst    <= '0;
            seq      <= '0;
        end else begin
            if (grant != '0) begin
                mreq_v_o <= 1'b1;
            end else if (mreq_rdy_i) begin
                mreq_v_o <= 1'b0;
            end
            for (int p = 0; p < ARB_PORTS; p++) begin
                if (grant[p]) begin
                    seq[p] <= seq[p] + 7'd1;
                end
                case ({grant[p], dec[p]})
                    2'b10:   outst[p] <= outst[p] + 4'd1;
                    2'b01:   outst[p] <= outst[p] - 4'd1;
                    default: outst[p] <= outst[p];
                endcase
            end
            resp_v_o <= dec;
            err_o    <= err_o | orphan;
        end
    end

    // Payload registers carry no reset; they are only meaningful under their valids.
    always_ff @(posedge clk_i) begin
        if (grant != '0) begin
            mreq_o     <= sel_req;
            mreq_o.tid <= {gnt_port, seq[gnt_port]};
        end
        if (mresp_v_i) begin
            resp0_o <= mresp_i;
            resp1_o <= mresp_i;
        end
    end

    // The held request always belongs to the port the arbiter granted last.
    always @(posedge clk_i) begin
        if (!rst_i && mreq_v_o) begin
            assert (mreq_o.tid[7] == last_gnt);
        end
    end

endmodule

// File: tb/tb_bw_memreq_arb.sv
// Randomized and directed scoreboard bench for bw_memreq_arb.
module tb_bw_memreq_arb;
    import rfBlackWidowPkg::*;

    localparam int MAX_OUT = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    MemoryRequest  req0_i, req1_i, mreq_o;
    MemoryResponse mresp_i, resp0_o, resp1_o;
    logic [1:0]    req_v_i, req_rdy_o, resp_v_o;
    logic          mreq_v_o, mreq_rdy_i, mresp_v_i, err_o;
    logic [3:0]    outst0_o, outst1_o;

    always #5 clk = ~clk;

    bw_memreq_arb #(.MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .req_v_i(req_v_i), .req_rdy_o(req_rdy_o),
        .mreq_o(mreq_o), .mreq_v_o(mreq_v_o), .mreq_rdy_i(mreq_rdy_i),
        .mresp_i(mresp_i), .mresp_v_i(mresp_v_i),
        .resp0_o(resp0_o), .resp1_o(resp1_o), .resp_v_o(resp_v_o),
        .outst0_o(outst0_o), .outst1_o(outst1_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per-port counters, sequence numbers and pending tids.
    int            m_outst [2];
    int            m_seq   [2];
    int            m_last;
    bit            m_busy;
    bit            m_err;
    MemoryRequest  q_mreq [$];
    MemoryResponse q_resp0 [$];
    MemoryResponse q_resp1 [$];
    logic [7:0]    pend0 [$];
    logic [7:0]    pend1 [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic MemoryRequest rnd_req();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return t[314:0];
    endfunction

    function automatic MemoryResponse rnd_resp();
        logic [639:0] t;
        for (int i = 0; i < 20; i++) t[i*32 +: 32] = $urandom;
        return t[618:0];
    endfunction

    task automatic model_reset();
        m_outst = '{0, 0};
        m_seq   = '{0, 0};
        m_last  = 1;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        q_mreq.delete();
        pend0.delete();
        pend1.delete();
    endtask

    // rsel: 0 none, 1 oldest port-0 tid, 2 oldest port-1 tid, 3 orphan tid 0x80.
    task automatic cycle(input bit r, input logic [1:0] v, input bit rdy, input int rsel);
        MemoryRequest  rq [2];
        MemoryRequest  e;
        MemoryResponse rs;
        bit            rv;
        bit            free, el0, el1;
        int            g, p;
        logic [1:0]    exp_rdy;
        @(posedge clk);
        #2;
        chk("outst0", 64'(outst0_o), 64'(m_outst[0]));
        chk("outst1", 64'(outst1_o), 64'(m_outst[1]));
        chk("mreq_v", 64'(mreq_v_o), 64'(m_busy));
        chk("err", 64'(err_o), 64'(m_err));
        rq[0] = rnd_req();
        rq[1] = rnd_req();
        rs    = rnd_resp();
        rv    = 1'b0;
        if (rsel == 1 && pend0.size() > 0) begin rs.tid = pend0.pop_front(); rv = 1'b1; end
        if (rsel == 2 && pend1.size() > 0) begin rs.tid = pend1.pop_front(); rv = 1'b1; end
        if (rsel == 3) begin rs.tid = 8'h80; rv = 1'b1; end
        rst_i = r; req_v_i = v; mreq_rdy_i = rdy;
        req0_i = rq[0]; req1_i = rq[1];
        mresp_i = rs; mresp_v_i = rv;
        #1;
        if (r) begin
            chk("rdy_in_reset", 64'(req_rdy_o), 64'd0);
            model_reset();
        end else begin
            free = !m_busy || rdy;
            el0  = v[0] && m_outst[0] < MAX_OUT && free;
            el1  = v[1] && m_outst[1] < MAX_OUT && free;
            g    = -1;
            if (el0 && el1) g = (m_last == 1) ? 0 : 1;
            else if (el0)   g = 0;
            else if (el1)   g = 1;
            exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
            chk("req_rdy", 64'(req_rdy_o), 64'(exp_rdy));
            if (rv) begin
                p = int'(rs.tid[7]);
                if (m_outst[p] == 0) m_err = 1'b1;
                else begin
                    m_outst[p]--;
                    if (p == 0) q_resp0.push_back(rs); else q_resp1.push_back(rs);
                end
            end
            if (g >= 0) begin
                e     = rq[g];
                e.tid = {1'(g), 7'(m_seq[g])};
                q_mreq.push_back(e);
                if (g == 0) pend0.push_back(e.tid); else pend1.push_back(e.tid);
                m_outst[g]++;
                m_seq[g] = (m_seq[g] + 1) % 128;
                m_last   = g;
                m_busy   = 1'b1;
            end else if (free) begin
                m_busy = 1'b0;
            end
        end
    endtask

    function automatic int pick();
        if (pend0.size() > 0) return 1;
        if (pend1.size() > 0) return 2;
        return 0;
    endfunction

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (pend0.size() == 0 && pend1.size() == 0 && !m_busy) break;
            cycle(0, 2'b00, 1'b1, pick());
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or a routed response.
    initial begin
        MemoryRequest  em;
        MemoryResponse er;
        forever begin
            @(negedge clk);
            if (mreq_v_o === 1'b1 && mreq_rdy_i === 1'b1) begin
                total++;
                if (q_mreq.size() == 0) begin
                    bad++;
                    $display("FAIL mreq_unexpected: got tid %0h expected no request", mreq_o.tid);
                end else begin
                    em = q_mreq.pop_front();
                    if (mreq_o !== em) begin
                        bad++;
                        $display("FAIL mreq: got tid %0h addr %0h data %0h expected tid %0h addr %0h data %0h",
                                 mreq_o.tid, mreq_o.addr, mreq_o.data[31:0], em.tid, em.addr, em.data[31:0]);
                    end
                end
            end
            if (resp_v_o === 2'b11) begin
                total++; bad++;
                $display("FAIL resp_onehot: got %b expected one-hot or zero", resp_v_o);
            end
            for (int p = 0; p < 2; p++) begin
                if (resp_v_o[p] === 1'b1) begin
                    total++;
                    if ((p == 0 && q_resp0.size() == 0) || (p == 1 && q_resp1.size() == 0)) begin
                        bad++;
                        $display("FAIL resp%0d_unexpected: got valid expected none", p);
                    end else begin
                        er = (p == 0) ? q_resp0.pop_front() : q_resp1.pop_front();
                        if (((p == 0) ? resp0_o : resp1_o) !== er) begin
                            bad++;
                            $display("FAIL resp%0d: got tid %0h expected tid %0h", p,
                                     (p == 0) ? resp0_o.tid : resp1_o.tid, er.tid);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; req_v_i = '0; mreq_rdy_i = 1'b0; mresp_v_i = 1'b0;
        req0_i = '0; req1_i = '0; mresp_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_resp_v", 64'(resp_v_o), 64'd0);
        cycle(1, 2'b11, 1'b0, 0);

        // Both ports from reset: tids 00, 80, 01, 81.
        repeat (4) cycle(0, 2'b11, 1'b1, 0);
        drain();

        // Port 1 saturates at MAX_OUT; port 0 keeps flowing; one response reopens port 1.
        repeat (4) cycle(0, 2'b10, 1'b1, 0);
        repeat (2) cycle(0, 2'b11, 1'b1, 0);
        cycle(0, 2'b11, 1'b1, 2);
        cycle(0, 2'b11, 1'b1, 0);
        drain();

        // Downstream stall for three cycles.
        cycle(0, 2'b01, 1'b1, 0);
        repeat (3) cycle(0, 2'b11, 1'b0, 0);
        cycle(0, 2'b11, 1'b1, 0);
        drain();

        // Grant and response on port 0 in the same cycle with two outstanding.
        repeat (2) cycle(0, 2'b01, 1'b1, 0);
        cycle(0, 2'b01, 1'b1, 1);
        cycle(0, 2'b00, 1'b1, 0);
        drain();

        // Sequence wrap on port 0.
        repeat (130) cycle(0, 2'b01, 1'b1, 1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(0, 2'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
        end
        drain();

        // Orphan response, then reset in the middle of a burst.
        cycle(0, 2'b00, 1'b1, 3);
        repeat (2) cycle(0, 2'b00, 1'b1, 0);
        repeat (3) cycle(0, 2'b11, 1'b1, 0);
        cycle(1, 2'b11, 1'b0, 0);
        repeat (3) cycle(0, 2'b00, 1'b1, 0);
        cycle(0, 2'b10, 1'b1, 0);
        drain();
        repeat (2) cycle(0, 2'b00, 1'b1, 0);

        @(posedge clk);
        #2;
        chk("mreq_queue_empty", 64'(q_mreq.size()), 64'd0);
        chk("resp_queues_empty", 64'(q_resp0.size() + q_resp1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
